// File: rtl/uacc_pkg.sv
// Shared types and helpers for the unary-rate output accumulator.
// Optional saturation is enabled by defining UACC_SAT_EN.
package uacc_pkg;

  localparam int UACC_WIDTH = 16;
  localparam int UACC_CNTW  = UACC_WIDTH - 1;
  localparam int UACC_ACCW  = 2 * UACC_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } uacc_state_e;

  // A programmed length of 0 stands for the full 2^cntw-cycle window.
  function automatic logic [31:0] uacc_decode_len(input logic [31:0] len,
                                                  input int unsigned cntw);
    return (len == 32'd0) ? (32'd1 << cntw) : len;
  endfunction

endpackage

// File: rtl/uacc_win_cnt.sv
// Window sample counter plus ones counter for the unary accumulator.
// Flags the last sample of the window and exposes the ones count including the current bit.
module uacc_win_cnt #(
  parameter int CNTW = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic            bit_in,
  input  logic [CNTW-1:0] last_idx,
  output logic [CNTW:0]   ones_next,
  output logic            last
);

  logic [CNTW-1:0] cnt;
  logic [CNTW:0]   ones;
  logic [CNTW:0]   ones_base;

  always_comb begin
    ones_base = load ? '0 : ones;
    ones_next = ones_base + {{CNTW{1'b0}}, bit_in};
    last      = (cnt == last_idx);
  end

  // The ones counter is one bit wider than cnt so a full window of ones never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      ones <= '0;
    end else if (load) begin
      cnt  <= CNTW'(1);
      ones <= ones_next;
    end else if (step) begin
      cnt  <= cnt + CNTW'(1);
      ones <= ones_next;
    end
  end

endmodule

// File: rtl/unary_acc.sv
// Output-stage accumulator: counts ones in the product bit stream over a window and
// adds/subtracts the count to a latched partial sum. Define UACC_SAT_EN for saturating add/sub.
module unary_acc
  import uacc_pkg::*;
#(
  parameter int WIDTH = UACC_WIDTH,
  parameter int CNTW  = WIDTH - 1,
  parameter int ACCW  = 2 * WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [CNTW-1:0] i_len,
  input  logic            i_bit,
  input  logic            i_sign,
  input  logic [ACCW-1:0] i_psum,
  output logic [ACCW-1:0] o_psum,
  output logic            o_valid,
  output logic            o_busy
);

  uacc_state_e     state;
  uacc_state_e     state_next;
  logic            accept;
  logic            run;
  logic            finish;
  logic            win_last;
  logic            start_one;
  logic [CNTW-1:0] start_last;
  logic [CNTW-1:0] last_lat;
  logic [CNTW:0]   ones_next;
  logic            sign_lat;
  logic            op_sign;
  logic [ACCW-1:0] psum_lat;
  logic [ACCW-1:0] op_psum;
  logic [ACCW-1:0] ones_ext;
  logic [ACCW-1:0] result;

  uacc_win_cnt #(.CNTW(CNTW)) u_win_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (run),
    .bit_in    (i_bit),
    .last_idx  (last_lat),
    .ones_next (ones_next),
    .last      (win_last)
  );

  // A start in DONE behaves exactly like one in IDLE, so sample 0 overlaps the DONE cycle.
  always_comb begin
    run        = (state == RUN);
    accept     = i_start && !run;
    start_last = CNTW'(uacc_decode_len(32'(i_len), CNTW) - 32'd1);
    start_one  = (start_last == '0);
    state_next = IDLE;
    if (accept) begin
      state_next = start_one ? DONE : RUN;
    end else if (run) begin
      state_next = win_last ? DONE : RUN;
    end
    finish   = (state_next == DONE);
    op_psum  = accept ? i_psum : psum_lat;
    op_sign  = accept ? i_sign : sign_lat;
    ones_ext = ACCW'(ones_next);
  end

`ifdef UACC_SAT_EN
  logic [ACCW:0] wide;

  // One guard bit suffices: the ones count is far smaller than the accumulator range.
  always_comb begin
    wide = op_sign ? ({op_psum[ACCW-1], op_psum} - {1'b0, ones_ext})
                   : ({op_psum[ACCW-1], op_psum} + {1'b0, ones_ext});
    if (wide[ACCW] != wide[ACCW-1]) begin
      result = wide[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
    end else begin
      result = wide[ACCW-1:0];
    end
  end
`else
  always_comb begin
    result = op_sign ? (op_psum - ones_ext) : (op_psum + ones_ext);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_lat <= '0;
      sign_lat <= 1'b0;
      psum_lat <= '0;
      o_psum   <= '0;
      o_valid  <= 1'b0;
    end else begin
      state   <= state_next;
      o_valid <= finish;
      if (accept) begin
        last_lat <= start_last;
        sign_lat <= i_sign;
        psum_lat <= i_psum;
      end
      if (finish) begin
        o_psum <= result;
      end
    end
  end

  assign o_busy = run;

endmodule

// File: tb/tb_unary_acc.sv
// Directed self-checking bench for unary_acc with default widths (WIDTH=16, ACCW=32).
// Expected saturation results follow UACC_SAT_EN.
module tb_unary_acc;

  logic        clk;
  logic        rst;
  logic        i_start;
  logic [14:0] i_len;
  logic        i_bit;
  logic        i_sign;
  logic [31:0] i_psum;
  logic [31:0] o_psum;
  logic        o_valid;
  logic        o_busy;

  int checks;
  int failures;
  int cycles;
  int busy_cycles;
  int valid_count;

  unary_acc dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (i_start),
    .i_len   (i_len),
    .i_bit   (i_bit),
    .i_sign  (i_sign),
    .i_psum  (i_psum),
    .o_psum  (o_psum),
    .o_valid (o_valid),
    .o_busy  (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic [14:0] len, input logic bit_v,
                               input logic sign, input logic [31:0] psum);
    i_start = start;
    i_len   = len;
    i_bit   = bit_v;
    i_sign  = sign;
    i_psum  = psum;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Bounded wait for o_valid; cycles stays 0 if it never arrives.
  task automatic waitValid(output int n_cycles, output int n_busy);
    n_cycles = 0;
    n_busy   = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (o_busy) n_busy++;
      if (o_valid) begin
        n_cycles = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    applyStimulus(1'b0, 15'd0, 1'b0, 1'b0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_psum", o_psum, 32'd0);
    checkOutput("reset_valid", 32'(o_valid), 32'd0);
    checkOutput("reset_busy", 32'(o_busy), 32'd0);
    rst = 1'b0;
    tick();

    // L=8, all ones, 100 + 8
    applyStimulus(1'b1, 15'd8, 1'b1, 1'b0, 32'd100);
    tick();
    i_start = 1'b0;
    waitValid(cycles, busy_cycles);
    checkOutput("l8_latency", 32'(cycles + 1), 32'd8);
    checkOutput("l8_busy_cycles", 32'(busy_cycles + 1), 32'd7);
    checkOutput("l8_psum", o_psum, 32'd108);
    tick();
    checkOutput("l8_valid_pulse", 32'(o_valid), 32'd0);
    checkOutput("l8_psum_hold", o_psum, 32'd108);
    checkOutput("l8_idle_busy", 32'(o_busy), 32'd0);

    // L=4, bits 1,0,1,1, -5 - 3 = -8
    applyStimulus(1'b1, 15'd4, 1'b1, 1'b1, 32'hFFFF_FFFB);
    tick();
    i_start = 1'b0;
    i_bit   = 1'b0;
    tick();
    i_bit = 1'b1;
    tick();
    i_bit = 1'b1;
    tick();
    checkOutput("l4_valid", 32'(o_valid), 32'd1);
    checkOutput("l4_psum", o_psum, 32'hFFFF_FFF8);
    i_bit = 1'b0;
    tick();
    i_bit = 1'b1;
    tick();
    checkOutput("l4_psum_after_toggle", o_psum, 32'hFFFF_FFF8);
    checkOutput("l4_no_extra_valid", 32'(o_valid), 32'd0);

    // L=1 goes straight to DONE
    applyStimulus(1'b1, 15'd1, 1'b1, 1'b0, 32'd0);
    tick();
    i_start = 1'b0;
    i_bit   = 1'b0;
    checkOutput("l1_valid", 32'(o_valid), 32'd1);
    checkOutput("l1_psum", o_psum, 32'd1);
    checkOutput("l1_busy", 32'(o_busy), 32'd0);
    tick();
    checkOutput("l1_valid_pulse", 32'(o_valid), 32'd0);

    // Start pulsed mid-RUN must not restart the L=8 window
    applyStimulus(1'b1, 15'd8, 1'b0, 1'b0, 32'd50);
    tick();
    i_start = 1'b0;
    tick();
    applyStimulus(1'b1, 15'd1, 1'b0, 1'b0, 32'd999);
    tick();
    i_start = 1'b0;
    i_psum  = 32'd0;
    waitValid(cycles, busy_cycles);
    checkOutput("midrun_latency", 32'(cycles + 3), 32'd8);
    checkOutput("midrun_psum", o_psum, 32'd50);
    tick();

    // Start held with L=2: windows of 2, 1 and 0 ones; sample 0 overlaps each DONE cycle
    applyStimulus(1'b1, 15'd2, 1'b1, 1'b0, 32'd0);
    tick();
    i_bit = 1'b1;
    tick();
    checkOutput("b2b_a_valid", 32'(o_valid), 32'd1);
    checkOutput("b2b_a_psum", o_psum, 32'd2);
    i_bit = 1'b1;
    tick();
    checkOutput("b2b_gap_valid", 32'(o_valid), 32'd0);
    checkOutput("b2b_gap_busy", 32'(o_busy), 32'd1);
    i_bit = 1'b0;
    tick();
    checkOutput("b2b_b_valid", 32'(o_valid), 32'd1);
    checkOutput("b2b_b_psum", o_psum, 32'd1);
    i_bit = 1'b0;
    tick();
    i_start = 1'b0;
    i_bit   = 1'b0;
    tick();
    checkOutput("b2b_c_valid", 32'(o_valid), 32'd1);
    checkOutput("b2b_c_psum", o_psum, 32'd0);
    tick();
    checkOutput("b2b_end_valid", 32'(o_valid), 32'd0);
    checkOutput("b2b_end_busy", 32'(o_busy), 32'd0);

    // Positive overflow: 2^31-2 + 4
    applyStimulus(1'b1, 15'd4, 1'b1, 1'b0, 32'h7FFF_FFFE);
    tick();
    i_start = 1'b0;
    repeat (3) tick();
    checkOutput("ovf_pos_valid", 32'(o_valid), 32'd1);
`ifdef UACC_SAT_EN
    checkOutput("ovf_pos_psum", o_psum, 32'h7FFF_FFFF);
`else
    checkOutput("ovf_pos_psum", o_psum, 32'h8000_0002);
`endif
    tick();

    // Negative overflow: -2^31+1 - 4
    applyStimulus(1'b1, 15'd4, 1'b1, 1'b1, 32'h8000_0001);
    tick();
    i_start = 1'b0;
    repeat (3) tick();
    checkOutput("ovf_neg_valid", 32'(o_valid), 32'd1);
`ifdef UACC_SAT_EN
    checkOutput("ovf_neg_psum", o_psum, 32'h8000_0000);
`else
    checkOutput("ovf_neg_psum", o_psum, 32'h7FFF_FFFD);
`endif
    tick();

    // Reset in the third RUN cycle of an L=8 window
    applyStimulus(1'b1, 15'd8, 1'b1, 1'b0, 32'd0);
    tick();
    i_start = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_psum", o_psum, 32'd0);
    checkOutput("abort_valid", 32'(o_valid), 32'd0);
    checkOutput("abort_busy", 32'(o_busy), 32'd0);
    tick();
    rst = 1'b0;
    valid_count = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_valid) valid_count++;
    end
    checkOutput("abort_no_valid", 32'(valid_count), 32'd0);
    applyStimulus(1'b1, 15'd2, 1'b1, 1'b0, 32'd20);
    tick();
    i_start = 1'b0;
    tick();
    checkOutput("post_reset_valid", 32'(o_valid), 32'd1);
    checkOutput("post_reset_psum", o_psum, 32'd22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
